alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand/result interface; the hardware counterpart of the bench driver/monitor pair.
- Accepts ALU commands on a valid/ready stream and buffers them in a FIFO.
- Issues commands one at a time to the ALU (OPA/OPB/CIN/CE/MODE/CMD/INP_VALID), waits the command's latency, then captures RES and flags and returns them on a valid/ready response port.
- Sits between a command source (sequencer, CPU bridge) and the ALU instance.

Parameters:
- N, 8, operand width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- LAT, 1, ALU cycles from issue to valid RES, non-multiply commands.
- MUL_LAT, 2, ALU cycles from issue to valid RES, multiply commands (MODE=1, CMD=9 or 10).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_opa  in  N  operand A.
- cmd_opb  in  N  operand B.
- cmd_cin  in  1  carry in.
- cmd_mode  in  1  1 = arithmetic, 0 = logical.
- cmd_op  in  4  ALU command code.
- cmd_inp_valid  in  2  operand-valid code, passed through.
- OPA  out  N  to ALU.
- OPB  out  N  to ALU.
- CIN  out  1  to ALU.
- CE  out  1  to ALU.
- MODE  out  1  to ALU.
- CMD  out  4  to ALU.
- INP_VALID  out  2  to ALU.
- RES  in  2N  from ALU.
- COUT, OFLOW, G, E, L, ERR  in  1 each  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_res  out  2N  captured RES.
- rsp_flags  out  6  captured {ERR,OFLOW,COUT,G,E,L}.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (RST low, async): FIFO empty; FSM IDLE; all outputs 0 except cmd_ready=1. Any in-flight command is dropped, with no response.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = !full; combinational from the registered count.
  - A pop at full does not enable a same-cycle push.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO non-empty, pop head into issue registers, go to ISSUE.
  - ISSUE (1 cycle): drive CE=1 and OPA/OPB/CIN/MODE/CMD/INP_VALID from issue registers. Load wait counter with MUL_LAT if MODE=1 and CMD in {9,10}, else LAT. Go to WAIT.
  - WAIT: CE=1 and all operand outputs held stable. Counter decrements each cycle; exit to CAPTURE when counter reaches 1, so WAIT lasts exactly lat cycles.
  - CAPTURE (1 cycle): register RES and flags into rsp_res/rsp_flags, set rsp_valid, drop CE and INP_VALID to 0. Go to RESP.
  - RESP: hold rsp_res, rsp_flags and rsp_valid stable until rsp_valid && rsp_ready. Then clear rsp_valid. If the FIFO is non-empty, pop and go directly to ISSUE (back-to-back); else go to IDLE.
- Outside ISSUE/WAIT: CE=0 and INP_VALID=0. OPA/OPB/CIN/MODE/CMD hold their last values.
- Timing: push into an empty FIFO at edge e0 gives rsp_valid high after edge e0+3+lat.
- INP_VALID=00 commands are issued unchanged; the ALU's ERR is captured as-is.
- Only one command is in flight at a time. No new issue occurs while a response is pending.

Optional Feature:
- Macro ALU_ISSUER_STATS_EN.
- When defined: add outputs stat_issued (16) and stat_err (16).
  - stat_issued increments on each ISSUE entry.
  - stat_err increments on each CAPTURE with ERR=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold RST=0 with cmd_valid=1 → cmd_ready=1, rsp_valid=0, CE=0, INP_VALID=0, busy=0, nothing pushed.
- ADD, LAT=1: opa=20, opb=22, op=0, mode=1, inp_valid=11 → CE high 2 cycles; rsp_valid after e0+4; rsp_res=42, rsp_flags=0.
- Multiply, MUL_LAT=2: op=9, mode=1 → CE high 3 cycles; rsp_valid after e0+5; rsp_res equals RES at CAPTURE.
- Full FIFO: DEPTH=4, rsp_ready=0, 6 back-to-back pushes → 5 accepted (1 in flight + 4 queued); cmd_ready low at the 6th until the first response is consumed.
- Backpressure and back-to-back: rsp_ready low for 10 cycles → rsp_res/rsp_flags stable and CE=0 throughout. On release, the next ISSUE occurs the following cycle with no IDLE cycle.
- Reset mid-WAIT: drive RST low during WAIT → CE=0 immediately (async), FIFO empty, and no response after reset release.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command stream, ALU operand/result and response buses for the ALU command issuer.
interface alu_cmd_issuer_if #(parameter int N = 8);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [N-1:0]   cmd_opa;
    logic [N-1:0]   cmd_opb;
    logic           cmd_cin;
    logic           cmd_mode;
    logic [3:0]     cmd_op;
    logic [1:0]     cmd_inp_valid;
    logic [N-1:0]   opa;
    logic [N-1:0]   opb;
    logic           cin;
    logic           ce;
    logic           mode;
    logic [3:0]     cmd;
    logic [1:0]     inp_valid;
    logic [2*N-1:0] res;
    logic           cout;
    logic           oflow;
    logic           g;
    logic           e;
    logic           l;
    logic           err;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_res;
    logic [5:0]     rsp_flags;

    modport master (
        input  cmd_valid, cmd_opa, cmd_opb, cmd_cin, cmd_mode, cmd_op, cmd_inp_valid,
        output cmd_ready,
        output opa, opb, cin, ce, mode, cmd, inp_valid,
        input  res, cout, oflow, g, e, l, err,
        output rsp_valid, rsp_res, rsp_flags,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_opa, cmd_opb, cmd_cin, cmd_mode, cmd_op, cmd_inp_valid,
        input  cmd_ready,
        input  opa, opb, cin, ce, mode, cmd, inp_valid,
        output res, cout, oflow, g, e, l, err,
        input  rsp_valid, rsp_res, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, issues one at a time, waits its latency, returns RES/flags.
// Optional ALU_ISSUER_STATS_EN adds saturating issued/error counters.
module alu_cmd_issuer #(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.master  bus,
    output logic              busy
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2((LAT > MUL_LAT ? LAT : MUL_LAT) + 1);

    typedef struct packed {
        logic [N-1:0] opa;
        logic [N-1:0] opb;
        logic         cin;
        logic         mode;
        logic [3:0]   op;
        logic [1:0]   iv;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

    state_t        state, next;
    cmd_t          mem [DEPTH];
    cmd_t          in_cmd, cur;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;
    logic          push, pop, is_mul;

    assign in_cmd        = {bus.cmd_opa, bus.cmd_opb, bus.cmd_cin, bus.cmd_mode, bus.cmd_op, bus.cmd_inp_valid};
    assign bus.cmd_ready = count != (AW+1)'(DEPTH);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign is_mul        = cur.mode && (cur.op == 4'd9 || cur.op == 4'd10);

    assign bus.opa       = cur.opa;
    assign bus.opb       = cur.opb;
    assign bus.cin       = cur.cin;
    assign bus.mode      = cur.mode;
    assign bus.cmd       = cur.op;
    assign bus.ce        = state == ISSUE || state == WAIT;
    assign bus.inp_valid = bus.ce ? cur.iv : 2'b00;
    assign bus.rsp_valid = state == RESP;
    assign busy          = count != '0 || state != IDLE;

    always_comb begin
        next = state;
        pop  = 1'b0;
        case (state)
            IDLE: begin
                pop  = count != '0;
                next = pop ? ISSUE : IDLE;
            end
            ISSUE:   next = WAIT;
            WAIT:    next = cnt == CW'(1) ? CAPTURE : WAIT;
            CAPTURE: next = RESP;
            RESP: if (bus.rsp_ready) begin
                pop  = count != '0;
                next = pop ? ISSUE : IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= in_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            cur           <= '0;
            cnt           <= '0;
            bus.rsp_res   <= '0;
            bus.rsp_flags <= '0;
        end else begin
            state <= next;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp  <= rp + 1'b1;
                cur <= mem[rp];
            end
            if (state == ISSUE) cnt <= is_mul ? CW'(MUL_LAT) : CW'(LAT);
            else if (state == WAIT) cnt <= cnt - 1'b1;
            if (state == CAPTURE) begin
                bus.rsp_res   <= bus.res;
                bus.rsp_flags <= {bus.err, bus.oflow, bus.cout, bus.g, bus.e, bus.l};
            end
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    // Every ISSUE entry coincides with a FIFO pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_err    <= '0;
        end else begin
            if (pop && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 1'b1;
            if (state == CAPTURE && bus.err && stat_err != 16'hFFFF) stat_err <= stat_err + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: table vectors, corner sequences and randomized traffic against a scoreboard and a latency-aware ALU model.
module tb_alu_cmd_issuer;
    localparam int N = 8;

    typedef struct packed {
        logic [7:0] opa;
        logic [7:0] opb;
        logic       cin;
        logic       mode;
        logic [3:0] op;
        logic [1:0] iv;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        logic [15:0] res;
        logic [5:0]  flags;
        int          lat;
    } vec_t;

    logic clk = 0;
    logic rst_n = 0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    cmd_t q[$];
    int   k;
    logic [1:0] iv_l;
    cmd_t cur_c;
    logic ok_t;
`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] stat_issued, stat_err;
`endif

    alu_cmd_issuer_if #(.N(N)) bus ();

    alu_cmd_issuer #(.N(N), .DEPTH(4), .LAT(1), .MUL_LAT(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy)
`ifdef ALU_ISSUER_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input cmd_t c);
        return (c.mode && (c.op == 4'd9 || c.op == 4'd10)) ? 2 : 1;
    endfunction

    function automatic logic [15:0] eres(input cmd_t c);
        if (c.mode && (c.op == 4'd9 || c.op == 4'd10)) return 16'(c.opa) * 16'(c.opb);
        if (c.mode) return 16'(c.opa) + 16'(c.opb) + 16'(c.cin);
        return {8'h00, c.opa ^ c.opb};
    endfunction

    function automatic logic [5:0] eflags(input cmd_t c);
        int  s   = int'(c.opa) + int'(c.opb) + int'(c.cin);
        logic mul = c.mode && (c.op == 4'd9 || c.op == 4'd10);
        logic cmp = c.mode && c.op == 4'd8;
        return {c.iv == 2'b00, 1'b0, c.mode && !mul && s > 255,
                cmp && c.opa > c.opb, cmp && c.opa == c.opb, cmp && c.opa < c.opb};
    endfunction

    // ALU model: RES is only correct in the cycle after CE was high for exactly lat+1 cycles.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else k <= bus.ce ? k + 1 : 0;
    always @(posedge clk)
        if (bus.ce) iv_l <= bus.inp_valid;
    assign cur_c = {bus.opa, bus.opb, bus.cin, bus.mode, bus.cmd, iv_l};
    assign ok_t  = !bus.ce && k == lat_of(cur_c) + 1;
    assign bus.res = ok_t ? eres(cur_c) : ~eres(cur_c);
    assign {bus.err, bus.oflow, bus.cout, bus.g, bus.e, bus.l} = ok_t ? eflags(cur_c) : ~eflags(cur_c);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input cmd_t c);
        bus.cmd_opa       = c.opa;
        bus.cmd_opb       = c.opb;
        bus.cmd_cin       = c.cin;
        bus.cmd_mode      = c.mode;
        bus.cmd_op        = c.op;
        bus.cmd_inp_valid = c.iv;
    endtask

    function automatic cmd_t rnd_cmd();
        return cmd_t'($urandom);
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    int   ce_n = 0;
    logic hold = 0;
    logic [21:0] prev_rsp;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ce_n = 0;
            hold = 0;
        end else begin
            if (bus.ce) begin
                ce_n++;
                if (q.size() > 0) chk("issue_fields", {bus.opa, bus.opb, bus.cin, bus.mode, bus.cmd, bus.inp_valid}, q[0]);
                else begin
                    checks++; errors++;
                    $display("FAIL issue_empty: CE high with no outstanding command");
                end
            end else if (ce_n != 0) begin
                if (q.size() > 0) chk("ce_len", ce_n, lat_of(q[0]) + 1);
                ce_n = 0;
            end
            if (hold && bus.rsp_valid) chk("rsp_hold", {bus.rsp_res, bus.rsp_flags, bus.ce}, {prev_rsp, 1'b0});
            hold     = bus.rsp_valid && !bus.rsp_ready;
            prev_rsp = {bus.rsp_res, bus.rsp_flags};
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() > 0) begin
                    chk("sb_res", bus.rsp_res, eres(q[0]));
                    chk("sb_flags", bus.rsp_flags, eflags(q[0]));
                    void'(q.pop_front());
                end else begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: response %0h with no command", bus.rsp_res);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) q.push_back({bus.cmd_opa, bus.cmd_opb, bus.cmd_cin, bus.cmd_mode, bus.cmd_op, bus.cmd_inp_valid});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tv [8];
    int   n, acc;
    logic seen;

    initial begin
        tv[0] = '{{8'd20,  8'd22,  1'b0, 1'b1, 4'd0,  2'b11}, 16'd42,  6'b000000, 1};
        tv[1] = '{{8'd12,  8'd11,  1'b0, 1'b1, 4'd9,  2'b11}, 16'd132, 6'b000000, 2};
        tv[2] = '{{8'd200, 8'd3,   1'b0, 1'b1, 4'd10, 2'b11}, 16'd600, 6'b000000, 2};
        tv[3] = '{{8'hF0,  8'h0F,  1'b0, 1'b0, 4'd9,  2'b11}, 16'd255, 6'b000000, 1};
        tv[4] = '{{8'd1,   8'd2,   1'b1, 1'b1, 4'd0,  2'b00}, 16'd4,   6'b100000, 1};
        tv[5] = '{{8'd200, 8'd100, 1'b0, 1'b1, 4'd0,  2'b11}, 16'd300, 6'b001000, 1};
        tv[6] = '{{8'd5,   8'd9,   1'b0, 1'b1, 4'd8,  2'b10}, 16'd14,  6'b000001, 1};
        tv[7] = '{{8'd7,   8'd7,   1'b0, 1'b1, 4'd8,  2'b01}, 16'd14,  6'b000010, 1};

        bus.rsp_ready = 0;
        bus.cmd_valid = 1;
        drive(rnd_cmd());
        repeat (3) tick;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_ce", bus.ce, 0);
        chk("rst_inp_valid", bus.inp_valid, 0);
        chk("rst_busy", busy, 0);
        bus.cmd_valid = 0;
        rst_n = 1;
        tick;
        tick;
        chk("rst_nothing_pushed", busy, 0);

        for (int i = 0; i < 8; i++) begin
            drive(tv[i].c);
            bus.cmd_valid = 1;
            tick;
            bus.cmd_valid = 0;
            n = 0;
            while (!bus.rsp_valid && n < 20) begin
                tick;
                n++;
            end
            chk("vec_latency", n, 3 + tv[i].lat);
            chk("vec_res", bus.rsp_res, tv[i].res);
            chk("vec_flags", bus.rsp_flags, tv[i].flags);
            bus.rsp_ready = 1;
            tick;
            bus.rsp_ready = 0;
            chk("vec_idle", busy, 0);
        end

        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(rnd_cmd());
            bus.cmd_valid = 1;
            if (bus.cmd_ready) acc++;
            tick;
        end
        bus.cmd_valid = 0;
        chk("full_accepted", acc, 5);
        chk("full_ready_low", bus.cmd_ready, 0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick;
            n++;
        end
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_ce_low", bus.ce, 0);
            chk("bp_ready_low", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1;
        tick;
        chk("b2b_issue", bus.ce, 1);
        chk("b2b_ready", bus.cmd_ready, 1);
        n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            tick;
            n++;
        end
        chk("full_drained", q.size(), 0);
        bus.rsp_ready = 0;

        drive({8'd9, 8'd9, 1'b0, 1'b1, 4'd9, 2'b11});
        bus.cmd_valid = 1;
        tick;
        drive({8'd1, 8'd1, 1'b0, 1'b1, 4'd0, 2'b11});
        tick;
        bus.cmd_valid = 0;
        n = 0;
        while (!bus.ce && n < 10) begin
            tick;
            n++;
        end
        tick;
        chk("mid_in_wait", bus.ce, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_ce_async", bus.ce, 0);
        chk("mid_inp_valid", bus.inp_valid, 0);
        chk("mid_fifo_empty", busy, 0);
        chk("mid_cmd_ready", bus.cmd_ready, 1);
        tick;
        tick;
        rst_n = 1;
        bus.rsp_ready = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bus.rsp_valid) seen = 1;
        end
        chk("mid_no_response", seen, 0);

        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = $urandom_range(0, 1) == 1;
            drive(rnd_cmd());
            bus.rsp_ready = $urandom_range(0, 3) != 0;
            tick;
        end
        bus.cmd_valid = 0;
        bus.rsp_ready = 1;
        n = 0;
        while ((busy || q.size() != 0) && n < 500) begin
            tick;
            n++;
        end
        chk("rand_drained", q.size(), 0);
        chk("rand_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
